instruction_fetch_unit: RTL

- Front end of the RV32I core. It sits directly upstream of the instruction decode/register-read stage and replaces the combinational instruction-memory lookup with a handshaked fetch engine.
- It holds the fetch PC and issues word requests to a variable-latency instruction memory, with at most one request outstanding.
- Returned instructions are buffered in a small FIFO and presented to decode with their PC over a valid/ready interface.
- A taken branch or jump from execute redirects fetch, flushes the buffer and discards any in-flight response.

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues one word request at a time to a
// variable-latency instruction memory, and buffers returned words with their PC in a small
// FIFO that feeds decode over a valid/ready handshake. A redirect from execute retargets
// fetch, flushes the buffer and drops any response still in flight.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [31:0]                   imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [31:0]                   imem_resp_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [31:0]                   inst_out,
  output logic [31:0]                   inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       req_pc_q;
  logic [31:0]       buf_pc_q   [FIFO_DEPTH];
  logic [31:0]       buf_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_next;

  logic accept;
  logic push;
  logic pop;

  // Handshake events; a redirect suppresses both the push and the pop of its cycle.
  always_comb begin
    accept = (state_q == StReq) && imem_req_ready;
    push   = (state_q == StWait) && imem_resp_valid && !redirect_valid;
    pop    = (count_q != '0) && inst_ready && !redirect_valid;
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CntW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect decides whether an in-flight response must be discarded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid || (count_q < DepthCnt)) state_d = StReq;
      end
      StReq: begin
        if (redirect_valid) begin
          state_d = accept ? StDiscard : StReq;
        end else if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          state_d = imem_resp_valid ? StReq : StDiscard;
        end else if (imem_resp_valid) begin
          state_d = (count_next < DepthCnt) ? StReq : StIdle;
        end
      end
      StDiscard: begin
        if (imem_resp_valid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: request from the state, decode view from the FIFO head (zero when empty).
  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = fetch_pc_q;
    inst_valid     = (count_q != '0);
    inst_out       = inst_valid ? buf_data_q[rd_ptr_q] : 32'h0;
    inst_pc        = inst_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
    fifo_count     = count_q;
  end

  // Fetch PC and the PC of the outstanding request; redirect wins over the post-accept advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (accept) begin
      req_pc_q   <= fetch_pc_q;
      fetch_pc_q <= fetch_pc_q + 32'd4;
    end
  end

  // FIFO pointers and occupancy; redirect flushes.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_next;
    end
  end

  // FIFO storage; contents are only visible through a valid head, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
      buf_data_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule
